// File: rtl/sph_pkg.sv
// ----------------------------------------------------------------------------
// sph_pkg
// Shared types and constants for the SPH particle pipeline.
//   SPH_DATA_WIDTH : default width of one fp16 field
//   task_type_e    : kind of sub-step a pass computes (density or force)
//   particle_t     : one particle BRAM word {x, p, rho}
//   task_t         : one pair task sent to compute {x_i, x_j, p_i, p_j, rho_j}
//   ST_*           : pair_dispatcher FSM state encodings
// ----------------------------------------------------------------------------
package sph_pkg;

    localparam int SPH_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        TASK_DENSITY = 2'b00,
        TASK_FORCE   = 2'b01
    } task_type_e;

    typedef struct packed {
        logic [SPH_DATA_WIDTH-1:0] x;
        logic [SPH_DATA_WIDTH-1:0] p;
        logic [SPH_DATA_WIDTH-1:0] rho;
    } particle_t;

    typedef struct packed {
        logic [SPH_DATA_WIDTH-1:0] x_i;
        logic [SPH_DATA_WIDTH-1:0] x_j;
        logic [SPH_DATA_WIDTH-1:0] p_i;
        logic [SPH_DATA_WIDTH-1:0] p_j;
        logic [SPH_DATA_WIDTH-1:0] rho_j;
    } task_t;

    // Dispatcher FSM encodings, kept as plain constants so the state register
    // reads the same in older tools and waveform viewers.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH_I = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/pair_dispatcher_rd_valid_pipe.sv
// ----------------------------------------------------------------------------
// rd_valid_pipe
// Shift register that follows each particle BRAM read through the memory's
// read latency, so the dispatcher knows which cycles carry valid rd_data.
// Ports:
//   clk_in     in  : system clock
//   rst        in  : synchronous active-high reset, clears all in-flight flags
//   in_valid   in  : a read address is being presented this cycle
//   tail_valid out : rd_data this cycle belongs to a tracked read
//   empty      out : no tracked reads in flight
// ----------------------------------------------------------------------------
module rd_valid_pipe
    import sph_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic in_valid,
    output logic tail_valid,
    output logic empty
);

    logic [RD_LATENCY-1:0] stage_q;
    logic [RD_LATENCY-1:0] stage_d;

    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi] = in_valid;
            end else begin : g_body
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // A read issued in cycle t sets stage 0 in t+1 and reaches the last stage
    // in t+RD_LATENCY, exactly when its data is on rd_data.
    assign tail_valid = stage_q[RD_LATENCY-1];
    assign empty      = ~|stage_q;

endmodule

// File: rtl/pair_dispatcher.sv
// ----------------------------------------------------------------------------
// pair_dispatcher
// Upstream task generator for the SPH compute stage. One pass walks every
// particle i; for each i it streams all j (self-pair included) as packed
// tasks {x_i, x_j, p_i, p_j, rho_j}, waits for compute's per-i result and
// writes it back to the result memory at address i.
// Ports:
//   clk_in, rst               : clock, synchronous active-high reset
//   start, cfg_task_type      : begin a pass (only from idle), pass task type
//   busy, done                : pass in progress / one-cycle completion pulse
//   rd_addr, rd_data          : particle BRAM read port, RD_LATENCY pipelined
//   valid_task, task_type,
//   task_data                 : task stream to compute
//   res_valid, res_data       : per-i result from compute
//   res_busy                  : compute terms in flight (observed only)
//   wr_en, wr_addr, wr_data   : result memory write port
// ----------------------------------------------------------------------------
module pair_dispatcher
    import sph_pkg::*;
#(
    parameter int DATA_WIDTH  = SPH_DATA_WIDTH,
    parameter int N_PARTICLES = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int RD_LATENCY  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              cfg_task_type,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [3*DATA_WIDTH-1:0] rd_data,
    output logic                    valid_task,
    output logic [1:0]              task_type,
    output logic [5*DATA_WIDTH-1:0] task_data,
    input  logic                    res_valid,
    input  logic [DATA_WIDTH-1:0]   res_data,
    input  logic                    res_busy,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N_PARTICLES - 1);
    localparam logic [2:0]            FETCH_LAST = 3'(RD_LATENCY - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]              state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   i_q,          i_d;
    logic [ADDR_WIDTH-1:0]   j_q,          j_d;
    logic [2:0]              fetch_cnt_q,  fetch_cnt_d;
    logic [DATA_WIDTH-1:0]   x_i_q,        x_i_d;
    logic [DATA_WIDTH-1:0]   p_i_q,        p_i_d;
    logic [1:0]              task_type_q,  task_type_d;
    logic                    busy_q,       busy_d;
    logic                    done_q,       done_d;
    logic                    valid_task_q, valid_task_d;
    logic [5*DATA_WIDTH-1:0] task_data_q,  task_data_d;
    logic                    wr_en_q,      wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q,    wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q,    wr_data_d;
    logic                    pending_q,    pending_d;

    logic                    issue_rd;
    logic                    tail_valid;
    logic                    pipe_empty;

    logic [DATA_WIDTH-1:0]   rd_x;
    logic [DATA_WIDTH-1:0]   rd_p;
    logic [DATA_WIDTH-1:0]   rd_rho;

    assign rd_x   = rd_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign rd_p   = rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign rd_rho = rd_data[DATA_WIDTH-1:0];

    // Compute occupancy never throttles the dispatcher; it is only brought
    // in so it is visible alongside the task stream.
    logic unused_res_busy;
    assign unused_res_busy = res_busy;

    // ------------------------------------------------------------------
    // In-flight read tracker
    // ------------------------------------------------------------------
    rd_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_valid_pipe (
        .clk_in     (clk_in),
        .rst        (rst),
        .in_valid   (issue_rd),
        .tail_valid (tail_valid),
        .empty      (pipe_empty)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        fetch_cnt_d = fetch_cnt_q;
        x_i_d       = x_i_q;
        p_i_d       = p_i_q;
        task_type_d = task_type_q;
        task_data_d = task_data_q;
        wr_data_d   = wr_data_q;
        pending_d   = pending_q;
        issue_rd    = 1'b0;

        // The per-i result can overtake the tail of the task stream, so it is
        // accepted in ISSUE as well as DRAIN. Only the first result for an i
        // is kept; a second one before the write-back is dropped.
        if ((state_q == ST_ISSUE || state_q == ST_DRAIN) && res_valid && !pending_q) begin
            pending_d = 1'b1;
            wr_data_d = res_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    task_type_d = cfg_task_type;
                    i_d         = '0;
                    j_d         = '0;
                    fetch_cnt_d = '0;
                    state_d     = ST_FETCH_I;
                end
            end

            // rd_addr holds i for RD_LATENCY cycles; the word for i lands on
            // rd_data in the first ISSUE cycle, where it is latched.
            ST_FETCH_I: begin
                if (fetch_cnt_q == FETCH_LAST) begin
                    j_d     = '0;
                    state_d = ST_ISSUE;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 3'd1;
                end
            end

            ST_ISSUE: begin
                issue_rd = 1'b1;
                if (j_q == '0) begin
                    x_i_d = rd_x;
                    p_i_d = rd_p;
                end
                // j stops at N-1 rather than wrapping.
                if (j_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (pipe_empty && (pending_q || res_valid)) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                pending_d = 1'b0;
                if (i_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    i_d         = i_q + 1'b1;
                    fetch_cnt_d = '0;
                    state_d     = ST_FETCH_I;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Task output is registered one cycle after the matching rd_data.
        valid_task_d = tail_valid;
        if (tail_valid) begin
            task_data_d = {x_i_q, rd_x, p_i_q, rd_p, rd_rho};
        end

        // Strobes are registered so they line up with the state they belong to.
        wr_en_d   = (state_d == ST_WRITE);
        wr_addr_d = (state_d == ST_WRITE) ? i_q : wr_addr_q;
        done_d    = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            j_q          <= '0;
            fetch_cnt_q  <= '0;
            x_i_q        <= '0;
            p_i_q        <= '0;
            task_type_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_task_q <= 1'b0;
            task_data_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            fetch_cnt_q  <= fetch_cnt_d;
            x_i_q        <= x_i_d;
            p_i_q        <= p_i_d;
            task_type_q  <= task_type_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            valid_task_q <= valid_task_d;
            task_data_q  <= task_data_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            pending_q    <= pending_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Read address is decoded from the counters: j while streaming pairs,
    // otherwise i (covers FETCH_I, and is 0 out of reset).
    assign rd_addr    = (state_q == ST_ISSUE) ? j_q : i_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign valid_task = valid_task_q;
    assign task_type  = task_type_q;
    assign task_data  = task_data_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_pair_dispatcher.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_pair_dispatcher
// Scoreboard bench: the stimulus sequence pushes expected tasks, writes and
// done pulses into queues; monitor processes pop and compare whenever a DUT
// presents valid_task, wr_en or done. Instance A: N=4, RD_LATENCY=2.
// Instance B: N=1, RD_LATENCY=1. Particle BRAM: x=k, p=10+k, rho=20+k.
// ----------------------------------------------------------------------------
module tb_pair_dispatcher;
    import sph_pkg::*;

    typedef struct { logic [79:0] data; logic [1:0] ttype; } exp_task_t;
    typedef struct { logic [1:0]  addr; logic [15:0] data; } exp_wr_t;
    typedef struct { int at; logic [15:0] d; } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] mem_word(input int k);
        return {16'(k), 16'(10 + k), 16'(20 + k)};
    endfunction

    // ---------------- instance A ----------------
    logic        rst_a, start_a, busy_a, done_a, valid_task_a, res_valid_a, res_busy_a, wr_en_a;
    logic [1:0]  cfg_a, rd_addr_a, task_type_a, wr_addr_a;
    logic [47:0] rd_data_a;
    logic [79:0] task_data_a;
    logic [15:0] res_data_a, wr_data_a;
    logic [1:0]  addr_a_d1 = '0, addr_a_d2 = '0;

    pair_dispatcher #(.DATA_WIDTH(16), .N_PARTICLES(4), .ADDR_WIDTH(2), .RD_LATENCY(2)) dut_a (
        .clk_in(clk), .rst(rst_a), .start(start_a), .cfg_task_type(cfg_a),
        .busy(busy_a), .done(done_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .valid_task(valid_task_a), .task_type(task_type_a), .task_data(task_data_a),
        .res_valid(res_valid_a), .res_data(res_data_a), .res_busy(res_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    // ---------------- instance B ----------------
    logic        rst_b, start_b, busy_b, done_b, valid_task_b, res_valid_b, res_busy_b, wr_en_b;
    logic [1:0]  cfg_b, task_type_b;
    logic [0:0]  rd_addr_b, wr_addr_b;
    logic [47:0] rd_data_b;
    logic [79:0] task_data_b;
    logic [15:0] res_data_b, wr_data_b;
    logic [0:0]  addr_b_d1 = '0;

    pair_dispatcher #(.DATA_WIDTH(16), .N_PARTICLES(1), .ADDR_WIDTH(1), .RD_LATENCY(1)) dut_b (
        .clk_in(clk), .rst(rst_b), .start(start_b), .cfg_task_type(cfg_b),
        .busy(busy_b), .done(done_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .valid_task(valid_task_b), .task_type(task_type_b), .task_data(task_data_b),
        .res_valid(res_valid_b), .res_data(res_data_b), .res_busy(res_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    // Pipelined BRAM models
    always @(posedge clk) begin
        addr_a_d1 <= rd_addr_a;
        addr_a_d2 <= addr_a_d1;
        addr_b_d1 <= rd_addr_b;
    end
    assign rd_data_a = mem_word(int'(addr_a_d2));
    assign rd_data_b = mem_word(int'(addr_b_d1));

    // ---------------- scoreboard state ----------------
    exp_task_t qa_task[$];
    exp_wr_t   qa_wr[$];
    int        exp_done_a = 0, done_cnt_a = 0, wr_cnt_a = 0, run_a = 0;
    exp_task_t qb_task[$];
    exp_wr_t   qb_wr[$];
    int        exp_done_b = 0, done_cnt_b = 0;

    // Compute model A: result = (x_i<<8) + sum(x_j + rho_j) over the first
    // m_after tasks of an i, presented m_delay cycles after that task; with
    // m_dup a second, different result follows one cycle later.
    int          m_tcnt = 0, m_after = 4, m_delay = 5, cyc = 0;
    bit          m_dup = 1'b0;
    logic [15:0] m_acc = '0;
    ev_t         m_q[$];

    initial begin
        task_t tsk;
        ev_t   ev;
        res_valid_a = 1'b0; res_data_a = '0; res_busy_a = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            res_valid_a = 1'b0;
            if (valid_task_a) begin
                tsk = task_data_a;
                if (m_tcnt == 0) m_acc = tsk.x_i << 8;
                m_acc = m_acc + tsk.x_j + tsk.rho_j;
                m_tcnt++;
                if (m_tcnt == m_after) begin
                    m_q.push_back('{at: cyc + m_delay, d: m_acc});
                    if (m_dup) m_q.push_back('{at: cyc + m_delay + 1, d: m_acc + 16'd1});
                end
                if (m_tcnt == 4) m_tcnt = 0;
            end
            if (m_q.size() > 0 && m_q[0].at <= cyc) begin
                ev = m_q.pop_front();
                res_valid_a = 1'b1;
                res_data_a  = ev.d;
            end
            res_busy_a = (m_tcnt != 0);
        end
    end

    // Compute model B: one task per i, result 3 cycles later.
    initial begin
        task_t       tsk;
        int          cd = 0;
        logic [15:0] hold = '0;
        res_valid_b = 1'b0; res_data_b = '0; res_busy_b = 1'b0;
        forever begin
            @(negedge clk);
            res_valid_b = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    res_valid_b = 1'b1;
                    res_data_b  = hold;
                end
            end
            if (valid_task_b) begin
                tsk  = task_data_b;
                hold = (tsk.x_i << 8) + tsk.x_j + tsk.rho_j;
                cd   = 3;
            end
            res_busy_b = (cd != 0);
        end
    end

    // ---------------- monitors ----------------
    initial begin
        exp_task_t e;
        exp_wr_t   w;
        logic      prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_task_a) begin
                run_a++;
                check("task_a_expected", qa_task.size() > 0, 1'b1);
                if (qa_task.size() > 0) begin
                    e = qa_task.pop_front();
                    $display("task_a data=%020h type=%0d", task_data_a, task_type_a);
                    check("task_a_data", task_data_a, e.data);
                    check("task_a_type", task_type_a, e.ttype);
                end
            end else if (run_a != 0) begin
                check("task_a_run_len", run_a, 4);
                run_a = 0;
            end
            if (wr_en_a) begin
                wr_cnt_a++;
                $display("write_a addr=%0d data=%0h", wr_addr_a, wr_data_a);
                check("wr_a_expected", qa_wr.size() > 0, 1'b1);
                if (qa_wr.size() > 0) begin
                    w = qa_wr.pop_front();
                    check("wr_a_addr", wr_addr_a, w.addr);
                    check("wr_a_data", wr_data_a, w.data);
                end
            end
            if (done_a) begin
                $display("done_a");
                check("done_a_expected", exp_done_a > 0, 1'b1);
                if (exp_done_a > 0) exp_done_a--;
                check("done_a_busy", busy_a, 1'b1);
                check("done_a_one_cycle", prev_done, 1'b0);
                done_cnt_a++;
            end
            prev_done = done_a;
        end
    end

    initial begin
        exp_task_t e;
        exp_wr_t   w;
        forever begin
            @(negedge clk);
            if (valid_task_b) begin
                $display("task_b data=%020h type=%0d", task_data_b, task_type_b);
                check("task_b_expected", qb_task.size() > 0, 1'b1);
                if (qb_task.size() > 0) begin
                    e = qb_task.pop_front();
                    check("task_b_data", task_data_b, e.data);
                    check("task_b_type", task_type_b, e.ttype);
                end
            end
            if (wr_en_b) begin
                $display("write_b addr=%0d data=%0h", wr_addr_b, wr_data_b);
                check("wr_b_expected", qb_wr.size() > 0, 1'b1);
                if (qb_wr.size() > 0) begin
                    w = qb_wr.pop_front();
                    check("wr_b_addr", wr_addr_b, w.addr[0]);
                    check("wr_b_data", wr_data_b, w.data);
                end
            end
            if (done_b) begin
                $display("done_b");
                check("done_b_expected", exp_done_b > 0, 1'b1);
                if (exp_done_b > 0) exp_done_b--;
                done_cnt_b++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_pass_a(input logic [1:0] tt, input int base);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                qa_task.push_back('{data: {16'(i), 16'(j), 16'(10 + i), 16'(10 + j), 16'(20 + j)}, ttype: tt});
            end
            qa_wr.push_back('{addr: 2'(i), data: 16'(256 * i + base)});
        end
        exp_done_a++;
    endtask

    task automatic start_pulse_a(input logic [1:0] tt);
        @(negedge clk);
        cfg_a   = tt;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt_a >= target) break;
        end
        check("done_a_seen", done_cnt_a >= target, 1'b1);
        @(negedge clk);
        check("busy_a_low_after_done", busy_a, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wr_base;
        rst_a = 1'b1; start_a = 1'b0; cfg_a = '0;
        rst_b = 1'b1; start_b = 1'b0; cfg_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_busy",       busy_a, 1'b0);
        check("rst_done",       done_a, 1'b0);
        check("rst_valid_task", valid_task_a, 1'b0);
        check("rst_wr_en",      wr_en_a, 1'b0);
        check("rst_rd_addr",    rd_addr_a, 2'd0);
        check("rst_wr_addr",    wr_addr_a, 2'd0);
        check("rst_task_data",  task_data_a, 80'd0);
        check("rst_wr_data",    wr_data_a, 16'd0);
        check("rst_task_type",  task_type_a, 2'd0);

        // Pass 1: density, result 5 cycles after the last task of each i.
        m_after = 4; m_delay = 5; m_dup = 1'b0;
        expect_pass_a(TASK_DENSITY, 92);
        start_pulse_a(TASK_DENSITY);
        wait_done_a(1, 400);

        // Pass 2: force; a second start with another type mid-pass is ignored.
        expect_pass_a(TASK_FORCE, 92);
        start_pulse_a(TASK_FORCE);
        repeat (20) @(negedge clk);
        start_pulse_a(2'b11);
        wait_done_a(2, 400);

        // Pass 3: reset during ISSUE of i=1 (start held in the same cycle).
        expect_pass_a(TASK_DENSITY, 92);
        wr_base = wr_cnt_a;
        start_pulse_a(TASK_DENSITY);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (wr_cnt_a > wr_base && valid_task_a) break;
        end
        check("mid_pass_reached", (wr_cnt_a > wr_base) && valid_task_a, 1'b1);
        rst_a   = 1'b1;
        start_a = 1'b1;
        qa_task.delete();
        qa_wr.delete();
        exp_done_a = 0;
        m_q.delete();
        m_tcnt = 0;
        run_a  = 0;
        @(posedge clk);
        #1;
        rst_a   = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        check("midrst_busy",       busy_a, 1'b0);
        check("midrst_done",       done_a, 1'b0);
        check("midrst_valid_task", valid_task_a, 1'b0);
        check("midrst_wr_en",      wr_en_a, 1'b0);
        check("midrst_rd_addr",    rd_addr_a, 2'd0);
        check("midrst_wr_addr",    wr_addr_a, 2'd0);
        check("midrst_task_data",  task_data_a, 80'd0);
        check("midrst_wr_data",    wr_data_a, 16'd0);
        check("midrst_task_type",  task_type_a, 2'd0);
        repeat (15) @(negedge clk);
        check("midrst_stays_idle", busy_a, 1'b0);

        // Pass 4: result in the same cycle as the last task, duplicate next cycle.
        m_after = 4; m_delay = 0; m_dup = 1'b1;
        expect_pass_a(TASK_DENSITY, 92);
        start_pulse_a(TASK_DENSITY);
        wait_done_a(3, 400);

        // Pass 5: result after the third task, duplicate arrives while pending.
        m_after = 3; m_delay = 0; m_dup = 1'b1;
        expect_pass_a(TASK_DENSITY, 66);
        start_pulse_a(TASK_DENSITY);
        wait_done_a(4, 400);
        repeat (5) @(negedge clk);

        // Instance B: single particle.
        qb_task.push_back('{data: {16'd0, 16'd0, 16'd10, 16'd10, 16'd20}, ttype: TASK_FORCE});
        qb_wr.push_back('{addr: 2'd0, data: 16'd20});
        exp_done_b = 1;
        @(negedge clk);
        cfg_b = TASK_FORCE;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (done_cnt_b >= 1) break;
        end
        check("done_b_seen", done_cnt_b, 1);
        @(negedge clk);
        check("busy_b_low_after_done", busy_b, 1'b0);
        repeat (5) @(negedge clk);

        check("a_tasks_left",  qa_task.size(), 0);
        check("a_writes_left", qa_wr.size(), 0);
        check("a_done_left",   exp_done_a, 0);
        check("b_tasks_left",  qb_task.size(), 0);
        check("b_writes_left", qb_wr.size(), 0);
        check("b_done_left",   exp_done_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
